addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pipe_if.sv | 31 +++
 rtl/addsub_pipe.sv | 137 +++++++++++++
 tb/tb_addsub_pipe.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result handshake bundle for the pipelined adder/subtractor.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry valid-ready flow control in each direction.
interface addsub_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             cb_o;
   logic             ovf;
   logic             zero;
   logic             neg;

   // Producer/consumer side: drives operands and result acceptance.
   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, d, cb_o, ovf, zero, neg
   );

   // Arithmetic block side.
   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, d, cb_o, ovf, zero, neg
   );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: WIDTH-bit add/subtract resolving CHUNK bits per stage, with carry/borrow, ovf, zero, neg flags.
// Latency: STAGES = WIDTH/CHUNK cycles from acceptance to out_valid, one result per cycle.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready = !out_valid || out_ready.
// Optional macro ADDSUB_PIPE_SAT_EN: clamp d to signed max/min on signed overflow.
module addsub_pipe #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input logic          clk,
   input logic          rst,
   addsub_pipe_if.slave bus
);
   localparam int STAGES = WIDTH / CHUNK;
   localparam int NMID   = (STAGES > 1) ? STAGES - 1 : 1;
   localparam int F      = STAGES - 1;

   // Registers between stage k and stage k+1 (operands travel with the op).
   logic             mid_v_q  [NMID];
   logic             mid_op_q [NMID];
   logic             mid_c_q  [NMID];
   logic [WIDTH-1:0] mid_a_q  [NMID];
   logic [WIDTH-1:0] mid_bx_q [NMID];
   logic [WIDTH-1:0] mid_s_q  [NMID];

   // Final stage doubles as the output register.
   logic             out_valid_q;
   logic [WIDTH-1:0] d_q;
   logic             cb_q;
   logic             ovf_q;
   logic             zero_q;
   logic             neg_q;

   // Per-stage views of what each stage is working on this cycle.
   logic             st_v  [STAGES];
   logic             st_op [STAGES];
   logic             st_c  [STAGES];
   logic [WIDTH-1:0] st_a  [STAGES];
   logic [WIDTH-1:0] st_bx [STAGES];
   logic [WIDTH-1:0] st_s  [STAGES];
   logic [CHUNK:0]   st_sum[STAGES];
   logic [WIDTH-1:0] stg_s_d[STAGES];

   logic             adv;
   logic [WIDTH-1:0] raw_d;
   logic [WIDTH-1:0] fin_d;
   logic             cb_d;
   logic             ovf_d;

   // Every stage moves together; a held output freezes everything behind it.
   assign adv          = !out_valid_q || bus.out_ready;
   assign bus.in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_src
         // Subtract is a + ~b + 1: invert b once at entry and feed op as carry-in.
         assign st_v[k]  = bus.in_valid;
         assign st_op[k] = bus.op;
         assign st_c[k]  = bus.op;
         assign st_a[k]  = bus.a;
         assign st_bx[k] = bus.op ? ~bus.b : bus.b;
         assign st_s[k]  = '0;
      end else begin : g_src
         assign st_v[k]  = mid_v_q[k-1];
         assign st_op[k] = mid_op_q[k-1];
         assign st_c[k]  = mid_c_q[k-1];
         assign st_a[k]  = mid_a_q[k-1];
         assign st_bx[k] = mid_bx_q[k-1];
         assign st_s[k]  = mid_s_q[k-1];
      end

      assign st_sum[k]  = {1'b0, st_a[k][k*CHUNK +: CHUNK]}
                        + {1'b0, st_bx[k][k*CHUNK +: CHUNK]}
                        + (CHUNK+1)'(st_c[k]);
      // Chunk k of the partial result is still zero here, so OR merges it in.
      assign stg_s_d[k] = st_s[k] | (WIDTH'(st_sum[k][CHUNK-1:0]) << (k*CHUNK));
   end

   // Final-stage result and flags; borrow is the inverted carry when subtracting.
   assign raw_d = stg_s_d[F];
   assign cb_d  = st_op[F] ? ~st_sum[F][CHUNK] : st_sum[F][CHUNK];
   assign ovf_d = (st_a[F][WIDTH-1] == st_bx[F][WIDTH-1]) && (raw_d[WIDTH-1] != st_a[F][WIDTH-1]);

`ifdef ADDSUB_PIPE_SAT_EN
   // Overflow direction follows the sign of a: positive overflow clamps to max, negative to min.
   assign fin_d = !ovf_d ? raw_d :
                  (st_a[F][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
   assign fin_d = raw_d;
`endif

   // Intermediate stages: shift one place on advance (bubbles included), clear on reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NMID; i++) begin
         if (rst) begin
            mid_v_q[i]  <= 1'b0;
            mid_op_q[i] <= 1'b0;
            mid_c_q[i]  <= 1'b0;
            mid_a_q[i]  <= '0;
            mid_bx_q[i] <= '0;
            mid_s_q[i]  <= '0;
         end else if (adv && (i < STAGES - 1)) begin
            mid_v_q[i]  <= st_v[i];
            mid_op_q[i] <= st_op[i];
            mid_c_q[i]  <= st_sum[i][CHUNK];
            mid_a_q[i]  <= st_a[i];
            mid_bx_q[i] <= st_bx[i];
            mid_s_q[i]  <= stg_s_d[i];
         end
      end
   end

   // Output register: loads the last stage on advance, holds while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         d_q         <= '0;
         cb_q        <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
      end else if (adv) begin
         out_valid_q <= st_v[F];
         d_q         <= fin_d;
         cb_q        <= cb_d;
         ovf_q       <= ovf_d;
         zero_q      <= (fin_d == '0);
         neg_q       <= fin_d[WIDTH-1];
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.d         = d_q;
   assign bus.cb_o      = cb_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.neg       = neg_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed and random stimulus for addsub_pipe at WIDTH=32, CHUNK=8.
// Latency: expects results 4 cycles after acceptance when unstalled.
// Backpressure: drives out_ready patterns and checks hold, ordering and reset flush.
module tb_addsub_pipe;
   localparam int W = 32;
   localparam int STAGES = 4;

`ifdef ADDSUB_PIPE_SAT_EN
   localparam logic [W-1:0] E_POS_OVF = 32'h7FFFFFFF;
   localparam logic         E_POS_NEG = 1'b0;
   localparam logic [W-1:0] E_NEG_OVF = 32'h80000000;
   localparam logic         E_NEG_NEG = 1'b1;
`else
   localparam logic [W-1:0] E_POS_OVF = 32'h80000000;
   localparam logic         E_POS_NEG = 1'b1;
   localparam logic [W-1:0] E_NEG_OVF = 32'h7FFFFFFF;
   localparam logic         E_NEG_NEG = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] d;
      logic         cb;
      logic         ovf;
      logic         zero;
      logic         neg;
   } res_t;

   logic clk;
   logic rst;

   addsub_pipe_if #(.WIDTH(W)) bus ();

   addsub_pipe #(.WIDTH(W), .CHUNK(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];

   // Values sampled during the most recent cycle, just before its rising edge.
   logic         ov_s, ir_s, acc_s, cb_s, ovf_s, zero_s, neg_s;
   logic [W-1:0] d_s;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: true integer arithmetic, then wrap or clamp to 32 bits.
   function automatic res_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      res_t        r;
      longint      s;
      logic [W:0]  u;
      if (!o) begin
         u    = {1'b0, x} + {1'b0, y};
         s    = longint'($signed(x)) + longint'($signed(y));
         r.cb = u[W];
      end else begin
         u    = {1'b0, x} - {1'b0, y};
         s    = longint'($signed(x)) - longint'($signed(y));
         r.cb = (x < y);
      end
      r.d   = u[W-1:0];
      r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef ADDSUB_PIPE_SAT_EN
      if (r.ovf) r.d = (s > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
      r.zero = (r.d == '0);
      r.neg  = r.d[W-1];
      return r;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h00000000;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h7FFFFFFF;
         3:       return 32'h80000000;
         default: return $urandom;
      endcase
   endfunction

   // One clock cycle: drive, sample before the edge, score transfers, step to the next negedge.
   task automatic cyc(input logic v, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ordy, input logic r);
      res_t e;
      bus.in_valid  = v;
      bus.op        = o;
      bus.a         = x;
      bus.b         = y;
      bus.out_ready = ordy;
      rst           = r;
      #1;
      ov_s   = bus.out_valid;
      ir_s   = bus.in_ready;
      d_s    = bus.d;
      cb_s   = bus.cb_o;
      ovf_s  = bus.ovf;
      zero_s = bus.zero;
      neg_s  = bus.neg;
      acc_s  = 1'b0;
      if (!r) begin
         chk("in_ready_rule", ir_s, !ov_s || ordy);
         if (ov_s && ordy) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", ov_s, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_d",    d_s,    e.d);
               chk("sb_cb",   cb_s,   e.cb);
               chk("sb_ovf",  ovf_s,  e.ovf);
               chk("sb_zero", zero_s, e.zero);
               chk("sb_neg",  neg_s,  e.neg);
            end
         end
         if (v && ir_s) begin
            exp_q.push_back(model(o, x, y));
            acc_s = 1'b1;
         end
      end
      @(posedge clk);
      if (r) exp_q.delete();
      @(negedge clk);
   endtask

   // Single unstalled op: exact latency plus spec-given constants.
   task automatic single(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ed, input logic ecb, input logic eovf,
                         input logic ezero, input logic eneg);
      cyc(1'b1, o, x, y, 1'b1, 1'b0);
      chk({tag, "_acc"}, acc_s, 1'b1);
      for (int i = 1; i <= STAGES; i++) begin
         cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
         if (i < STAGES) chk({tag, "_early"}, ov_s, 1'b0);
      end
      chk({tag, "_lat"},  ov_s,   1'b1);
      chk({tag, "_d"},    d_s,    ed);
      chk({tag, "_cb"},   cb_s,   ecb);
      chk({tag, "_ovf"},  ovf_s,  eovf);
      chk({tag, "_zero"}, zero_s, ezero);
      chk({tag, "_neg"},  neg_s,  eneg);
   endtask

   initial begin
      int           sent;
      int           stall_left;
      logic         stalled_once;
      logic         ordy;
      logic         cur_op;
      logic [W-1:0] cur_a, cur_b;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);

      // Reset state.
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      chk("rst_out_valid", ov_s,   1'b0);
      chk("rst_in_ready",  ir_s,   1'b1);
      chk("rst_d",         d_s,    32'h0);
      chk("rst_cb",        cb_s,   1'b0);
      chk("rst_ovf",       ovf_s,  1'b0);
      chk("rst_zero",      zero_s, 1'b0);
      chk("rst_neg",       neg_s,  1'b0);

      // Directed vectors.
      single("sub_5_3",     1'b1, 32'd5,        32'd3,        32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0);
      single("sub_0_1",     1'b1, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
      single("sub_eq",      1'b1, 32'h1234,     32'h1234,     32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);
      single("add_posovf",  1'b0, 32'h7FFFFFFF, 32'd1,        E_POS_OVF,    1'b0, 1'b1, 1'b0, E_POS_NEG);
      single("sub_negovf",  1'b1, 32'h80000000, 32'd1,        E_NEG_OVF,    1'b0, 1'b1, 1'b0, E_NEG_NEG);
      single("add_wrap",    1'b0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
      single("add_c8",      1'b0, 32'h000000FF, 32'd1,        32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0);
      single("add_c24",     1'b0, 32'h00FFFFFF, 32'd1,        32'h01000000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Backpressure: 8 back-to-back ops, 3-cycle stall once results appear.
      sent         = 0;
      stall_left   = 0;
      stalled_once = 1'b0;
      cur_op       = 1'($urandom);
      cur_a        = pick();
      cur_b        = pick();
      for (int t = 0; t < 60 && (sent < 8 || exp_q.size() > 0); t++) begin
         ordy = 1'b1;
         if (!stalled_once && bus.out_valid) begin
            stalled_once = 1'b1;
            stall_left   = 3;
         end
         if (stall_left > 0) begin
            ordy = 1'b0;
            stall_left--;
         end
         cyc(sent < 8, cur_op, cur_a, cur_b, ordy, 1'b0);
         if (!ordy) begin
            chk("stall_in_ready", ir_s, 1'b0);
            chk("stall_ov",       ov_s, 1'b1);
            if (exp_q.size() > 0) chk("stall_hold_d", d_s, exp_q[0].d);
         end
         if (acc_s) begin
            sent++;
            cur_op = 1'($urandom);
            cur_a  = pick();
            cur_b  = pick();
         end
      end
      chk("stall_seen",    stalled_once, 1'b1);
      chk("stall_sent",    sent, 8);
      chk("stall_drained", exp_q.size(), 0);

      // Reset with three ops in flight.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, pick(), pick(), 1'b1, 1'b0);
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      chk("flush_ov", ov_s, 1'b0);
      chk("flush_ir", ir_s, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
         chk("flush_quiet", ov_s, 1'b0);
      end
      single("post_rst", 1'b0, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random traffic with random backpressure.
      for (int t = 0; t < 300; t++) begin
         cyc($urandom_range(0, 3) != 0, 1'($urandom), pick(), pick(), $urandom_range(0, 3) != 0, 1'b0);
      end
      for (int t = 0; t < 20 && exp_q.size() > 0; t++) cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      chk("rand_drained", exp_q.size(), 0);
      cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      chk("end_idle", ov_s, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
